// File: rtl/sweep_pkg.sv
// Shared definitions for the servo sweep controller and the PWM stage:
// state encoding, direction codes and default pulse-width limits.
package sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SWEEP = 2'b01,
    ST_SEEK  = 2'b10
  } sweep_state_t;

  typedef enum logic [1:0] {
    DIR_STOP = 2'b00,
    DIR_INC  = 2'b01,
    DIR_DEC  = 2'b10
  } sweep_dir_t;

  localparam int unsigned DEF_MIN_PW = 5000;
  localparam int unsigned DEF_MAX_PW = 25000;
  localparam int unsigned SAMPLE_W   = 12;
  localparam int unsigned PW_W       = 32;

endpackage

// File: rtl/max_capture.sv
// Compare-and-hold of the largest sample and the servo position where it occurred.
// Strictly-greater compare keeps the earliest position on ties.
module max_capture
  import sweep_pkg::*;
#(
  parameter int unsigned INIT_POS = DEF_MIN_PW
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                clear,
  input  logic                drop_pos,
  input  logic                valid,
  input  logic [SAMPLE_W-1:0] data,
  input  logic [PW_W-1:0]     position,
  output logic [SAMPLE_W-1:0] max_value,
  output logic [PW_W-1:0]     max_pos
);

  localparam logic [PW_W-1:0] INIT_POS_L = PW_W'(INIT_POS);

  logic take;
  assign take = valid && (data > max_value);

  always_ff @(posedge CLK) begin
    if (RST || clear) begin
      max_value <= '0;
      max_pos   <= INIT_POS_L;
    end else begin
      if (take) begin
        max_value <= data;
      end
      // drop_pos discards the position but a final sample still updates the value
      if (drop_pos) begin
        max_pos <= INIT_POS_L;
      end else if (take) begin
        max_pos <= position;
      end
    end
  end

endmodule

// File: rtl/sweep_ctrl.sv
// Servo calibration sweep: ramps the servo, records the brightest position,
// then drives the servo back to that position for a fixed settle time.
module sweep_ctrl
  import sweep_pkg::*;
#(
  parameter int unsigned MIN_PW         = DEF_MIN_PW,
  parameter int unsigned MAX_PW         = DEF_MAX_PW,
  parameter int unsigned SETTLE_CYCLES  = 200000,
  parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                START,
  input  logic                SENSOR_VALID,
  input  logic [SAMPLE_W-1:0] SENSOR_DATA,
  input  logic [PW_W-1:0]     pulseWidth,
  output logic                EN,
  output logic [1:0]          DIR,
  output logic                ES,
  output logic                MC,
  output logic [PW_W-1:0]     pulseWidth_max,
  output logic [SAMPLE_W-1:0] max_val,
  output logic                BUSY,
  output logic                DONE,
  output logic                ERR
);

  localparam logic [31:0] MAX_PW_L      = 32'(MAX_PW);
  localparam logic [31:0] TIMEOUT_LAST  = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] SETTLE_LAST   = 32'(SETTLE_CYCLES - 1);

  sweep_state_t state, next_state;
  logic [31:0]  cnt;

  logic         cap_clear, cap_valid, cap_drop;
  logic         done_d, err_d, en_d, es_d, mc_d, busy_d;
  sweep_dir_t   dir_d;
  logic         at_end;

  assign at_end = SENSOR_VALID && (pulseWidth >= MAX_PW_L);

  always_comb begin
    next_state = state;
    cap_clear  = 1'b0;
    cap_valid  = 1'b0;
    cap_drop   = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (START) begin
          next_state = ST_SWEEP;
          cap_clear  = 1'b1;
        end
      end
      ST_SWEEP: begin
        cap_valid = SENSOR_VALID;
        // end-of-sweep sample wins over a timeout in the same cycle
        if (at_end) begin
          next_state = ST_SEEK;
        end else if (cnt == TIMEOUT_LAST) begin
          next_state = ST_IDLE;
          cap_drop   = 1'b1;
          err_d      = 1'b1;
        end
      end
      ST_SEEK: begin
        if (cnt == SETTLE_LAST) begin
          next_state = ST_IDLE;
          done_d     = 1'b1;
        end
      end
      default: next_state = ST_IDLE;
    endcase

    // outputs decoded from the upcoming state so the registers line up with it
    en_d   = (next_state != ST_IDLE);
    busy_d = (next_state != ST_IDLE);
    es_d   = (next_state == ST_SWEEP);
    mc_d   = (next_state == ST_SEEK);
    unique case (next_state)
      ST_SWEEP: dir_d = DIR_INC;
      ST_SEEK:  dir_d = DIR_DEC;
      default:  dir_d = DIR_STOP;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
      cnt   <= '0;
      EN    <= 1'b0;
      DIR   <= DIR_STOP;
      ES    <= 1'b0;
      MC    <= 1'b0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      ERR   <= 1'b0;
    end else begin
      state <= next_state;
      if ((next_state != state) || (state == ST_IDLE)) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 32'd1;
      end
      EN   <= en_d;
      DIR  <= dir_d;
      ES   <= es_d;
      MC   <= mc_d;
      BUSY <= busy_d;
      DONE <= done_d;
      ERR  <= err_d;
    end
  end

  max_capture #(
    .INIT_POS (MIN_PW)
  ) u_max_capture (
    .CLK       (CLK),
    .RST       (RST),
    .clear     (cap_clear),
    .drop_pos  (cap_drop),
    .valid     (cap_valid),
    .data      (SENSOR_DATA),
    .position  (pulseWidth),
    .max_value (max_val),
    .max_pos   (pulseWidth_max)
  );

endmodule

// File: tb/tb_sweep_ctrl.sv
// Scoreboard bench for sweep_ctrl: sweeps push their expected outcome, a monitor
// checks each DONE/ERR pulse against it.
module tb_sweep_ctrl;
  import sweep_pkg::*;

  localparam int unsigned MIN_PW  = 5000;
  localparam int unsigned MAX_PW  = 25000;
  localparam int unsigned SETTLE  = 200;
  localparam int unsigned TIMEOUT = 1000;

  logic        CLK = 1'b0;
  logic        RST, START, SENSOR_VALID;
  logic [11:0] SENSOR_DATA;
  logic [31:0] pulseWidth;
  logic        EN, ES, MC, BUSY, DONE, ERR;
  logic [1:0]  DIR;
  logic [31:0] pulseWidth_max;
  logic [11:0] max_val;

  sweep_ctrl #(
    .MIN_PW         (MIN_PW),
    .MAX_PW         (MAX_PW),
    .SETTLE_CYCLES  (SETTLE),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .START          (START),
    .SENSOR_VALID   (SENSOR_VALID),
    .SENSOR_DATA    (SENSOR_DATA),
    .pulseWidth     (pulseWidth),
    .EN             (EN),
    .DIR            (DIR),
    .ES             (ES),
    .MC             (MC),
    .pulseWidth_max (pulseWidth_max),
    .max_val        (max_val),
    .BUSY           (BUSY),
    .DONE           (DONE),
    .ERR            (ERR)
  );

  always #5 CLK = ~CLK;

  int unsigned ecount = 0;
  always @(posedge CLK) ecount <= ecount + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, ecount);
    end
  endtask

  typedef struct {
    bit          is_err;
    logic [11:0] mv;
    logic [31:0] pw;
    int unsigned at;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [31:0] pw;
    bit          v;
    logic [11:0] d;
  } smp_t;

  // monitor: every completion pulse must match the oldest expected outcome
  always @(negedge CLK) begin
    exp_t e;
    if (DONE === 1'b1 || ERR === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_end: DONE=%0b ERR=%0b with nothing expected", DONE, ERR);
      end else begin
        e = sbq.pop_front();
        chk("end_done", {31'd0, DONE}, {31'd0, !e.is_err});
        chk("end_err", {31'd0, ERR}, {31'd0, e.is_err});
        chk("end_max_val", {20'd0, max_val}, {20'd0, e.mv});
        chk("end_pw_max", pulseWidth_max, e.pw);
        chk("end_cycle", ecount, e.at);
      end
    end
  end

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic check_outputs(input string tag, input bit en, input logic [1:0] dir,
                               input bit es, input bit mc, input bit busy);
    chk({tag, "_EN"}, {31'd0, EN}, {31'd0, en});
    chk({tag, "_DIR"}, {30'd0, DIR}, {30'd0, dir});
    chk({tag, "_ES"}, {31'd0, ES}, {31'd0, es});
    chk({tag, "_MC"}, {31'd0, MC}, {31'd0, mc});
    chk({tag, "_BUSY"}, {31'd0, BUSY}, {31'd0, busy});
  endtask

  // Reference: a sweep keeps the first position holding the strictly largest
  // sample and ends on the first valid sample at or beyond MAX_PW.
  task automatic run_sweep(input smp_t s[$], input bit noise,
                           output logic [11:0] mv, output logic [31:0] pos);
    START = 1'b1;
    step();
    START = 1'b0;
    check_outputs("sweep", 1'b1, 2'b01, 1'b1, 1'b0, 1'b1);
    chk("sweep_clear_max", {20'd0, max_val}, 32'd0);
    chk("sweep_clear_pw", pulseWidth_max, MIN_PW);
    mv  = '0;
    pos = MIN_PW;
    foreach (s[i]) begin
      pulseWidth   = s[i].pw;
      SENSOR_VALID = s[i].v;
      SENSOR_DATA  = s[i].d;
      START        = noise && ($urandom % 8 == 0);
      step();
      if (s[i].v && s[i].d > mv) begin
        mv  = s[i].d;
        pos = s[i].pw;
      end
      if (s[i].v && s[i].pw >= MAX_PW) begin
        sbq.push_back('{is_err: 1'b0, mv: mv, pw: pos, at: ecount + SETTLE});
        break;
      end
    end
    START        = 1'b0;
    SENSOR_VALID = 1'b0;
    check_outputs("seek", 1'b1, 2'b10, 1'b0, 1'b1, 1'b1);
    chk("seek_max_val", {20'd0, max_val}, {20'd0, mv});
    chk("seek_pw_max", pulseWidth_max, pos);
  endtask

  task automatic finish_seek(input bit noise, input logic [11:0] mv, input logic [31:0] pos);
    for (int i = 0; i < int'(SETTLE) + 10 && sbq.size() != 0; i++) begin
      SENSOR_VALID = noise && ($urandom % 2 == 0);
      SENSOR_DATA  = 12'hFFF;
      START        = noise && (sbq.size() != 0) && (ecount < sbq[0].at) && ($urandom % 16 == 0);
      step();
    end
    START        = 1'b0;
    SENSOR_VALID = 1'b0;
    chk("done_seen_pending", sbq.size(), 32'd0);
    sbq.delete();
    step();
    // samples in IDLE must not disturb the held result
    SENSOR_VALID = 1'b1;
    SENSOR_DATA  = 12'hFFF;
    step();
    step();
    SENSOR_VALID = 1'b0;
    check_outputs("idle", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    chk("idle_DONE", {31'd0, DONE}, 32'd0);
    chk("idle_max_val", {20'd0, max_val}, {20'd0, mv});
    chk("idle_pw_max", pulseWidth_max, pos);
  endtask

  function automatic void rand_sweep(output smp_t s[$]);
    logic [31:0] pw;
    smp_t        x;
    s  = {};
    pw = MIN_PW;
    forever begin
      x.pw = pw;
      x.v  = ($urandom % 3 == 0) || (pw >= MAX_PW);
      x.d  = ($urandom % 2 == 0) ? 12'(($urandom % 16) * 256) : 12'($urandom % 4096);
      s.push_back(x);
      if (x.v && pw >= MAX_PW) break;
      pw = pw + 50 + ($urandom % 400);
    end
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    smp_t        s[$];
    logic [11:0] mv;
    logic [31:0] pos;
    int unsigned s_edge;

    RST          = 1'b1;
    START        = 1'b1;
    SENSOR_VALID = 1'b0;
    SENSOR_DATA  = '0;
    pulseWidth   = MIN_PW;
    step();
    step();
    check_outputs("reset", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    chk("reset_DONE", {31'd0, DONE}, 32'd0);
    chk("reset_ERR", {31'd0, ERR}, 32'd0);
    chk("reset_max_val", {20'd0, max_val}, 32'd0);
    chk("reset_pw_max", pulseWidth_max, MIN_PW);
    RST   = 1'b0;
    START = 1'b0;
    step();
    chk("post_reset_BUSY", {31'd0, BUSY}, 32'd0);

    // basic sweep
    s = '{'{32'd5000, 1'b1, 12'd100}, '{32'd13000, 1'b1, 12'd900}, '{32'd25000, 1'b1, 12'd400}};
    run_sweep(s, 1'b0, mv, pos);
    finish_seek(1'b0, mv, pos);

    // tie keeps the earlier position
    s = '{'{32'd9000, 1'b1, 12'd700}, '{32'd17000, 1'b1, 12'd700}, '{32'd25000, 1'b1, 12'd0}};
    run_sweep(s, 1'b1, mv, pos);
    finish_seek(1'b1, mv, pos);

    // full-scale sample on the exit cycle; unqualified samples at MAX_PW do not end the sweep
    s = '{'{32'd5000, 1'b1, 12'd10}, '{32'd25000, 1'b0, 12'd4095}, '{32'd25000, 1'b1, 12'd4095}};
    run_sweep(s, 1'b0, mv, pos);
    finish_seek(1'b0, mv, pos);

    // timeout with the servo stuck short of MAX_PW
    s  = {};
    mv = '0;
    for (int i = 0; i < int'(TIMEOUT); i++) begin
      smp_t x;
      x.pw = 32'd9000;
      x.v  = ($urandom % 4 == 0);
      x.d  = 12'($urandom % 4096);
      s.push_back(x);
      if (x.v && x.d > mv) mv = x.d;
    end
    START = 1'b1;
    step();
    START  = 1'b0;
    s_edge = ecount;
    sbq.push_back('{is_err: 1'b1, mv: mv, pw: MIN_PW, at: s_edge + TIMEOUT});
    foreach (s[i]) begin
      pulseWidth   = s[i].pw;
      SENSOR_VALID = s[i].v;
      SENSOR_DATA  = s[i].d;
      step();
    end
    SENSOR_VALID = 1'b0;
    step();
    chk("err_seen_pending", sbq.size(), 32'd0);
    sbq.delete();
    check_outputs("after_err", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    chk("after_err_ERR", {31'd0, ERR}, 32'd0);
    chk("after_err_pw_max", pulseWidth_max, MIN_PW);

    // reset in the middle of SEEK, together with START
    rand_sweep(s);
    run_sweep(s, 1'b1, mv, pos);
    for (int i = 0; i < 20; i++) step();
    RST   = 1'b1;
    START = 1'b1;
    step();
    RST   = 1'b0;
    START = 1'b0;
    sbq.delete();
    check_outputs("rst_seek", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    chk("rst_seek_DONE", {31'd0, DONE}, 32'd0);
    chk("rst_seek_max_val", {20'd0, max_val}, 32'd0);
    chk("rst_seek_pw_max", pulseWidth_max, MIN_PW);
    for (int i = 0; i < int'(SETTLE) + 5; i++) step();
    chk("rst_seek_stay_idle", {31'd0, BUSY}, 32'd0);

    // randomized sweeps with stray START and sensor activity
    for (int n = 0; n < 8; n++) begin
      rand_sweep(s);
      run_sweep(s, 1'b1, mv, pos);
      finish_seek(1'b1, mv, pos);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sweep_ctrl.md
SWEEP_CTRL -- requirements
Module: sweep_ctrl

Interface
REQ-001 Parameter MIN_PW, default 5000, minimum servo high time in clock cycles (0 deg).
REQ-002 Parameter MAX_PW, default 25000, sweep end high time (180 deg).
REQ-003 Parameter SETTLE_CYCLES, default 200000, cycles spent driving the servo back to the max position.
REQ-004 Parameter TIMEOUT_CYCLES, default 50000000, maximum cycles allowed in SWEEP.
REQ-005 CLK  in  1  clock; all logic on posedge.
REQ-006 RST  in  1  synchronous, active-high reset.
REQ-007 START  in  1  single-cycle request to begin a calibration sweep.
REQ-008 SENSOR_VALID  in  1  irradiance sample strobe, one cycle per sample.
REQ-009 SENSOR_DATA  in  12  unsigned irradiance sample, qualified by SENSOR_VALID.
REQ-010 pulseWidth  in  32  current servo high time reported by the PWM stage.
REQ-011 EN  out  1  PWM stage enable.
REQ-012 DIR  out  2  sweep direction: 00 stop, 01 increasing, 10 decreasing/seek.
REQ-013 ES  out  1  sweep-active flag to the PWM stage.
REQ-014 MC  out  1  max-seek flag; PWM stage drives pulseWidth_max.
REQ-015 pulseWidth_max  out  32  high time at which the largest sample was seen.
REQ-016 max_val  out  12  largest sample of the current or last sweep.
REQ-017 BUSY  out  1  high in SWEEP and SEEK.
REQ-018 DONE  out  1  one-cycle pulse on successful completion.
REQ-019 ERR  out  1  one-cycle pulse on sweep timeout.

Function
REQ-020 States SHALL be IDLE, SWEEP, SEEK; all outputs SHALL be registered and change one cycle after the state change.
REQ-021 IDLE: EN=0, DIR=00, ES=0, MC=0, BUSY=0; pulseWidth_max and max_val hold last results.
REQ-022 START in IDLE SHALL enter SWEEP, clear max_val to 0, load pulseWidth_max with MIN_PW, clear timeout counter.
REQ-023 START while BUSY SHALL be ignored.
REQ-024 SWEEP: EN=1, DIR=01, ES=1, MC=0, BUSY=1.
REQ-025 In SWEEP, SENSOR_VALID with SENSOR_DATA strictly greater than max_val SHALL update max_val to SENSOR_DATA and pulseWidth_max to pulseWidth in the same cycle; ties SHALL keep the earlier position.
REQ-026 SWEEP SHALL exit to SEEK on the cycle SENSOR_VALID is high with pulseWidth >= MAX_PW, after applying REQ-025 to that sample.
REQ-027 Timeout counter SHALL increment every SWEEP cycle; on reaching TIMEOUT_CYCLES-1 without REQ-026, go to IDLE, pulse ERR, and set pulseWidth_max to MIN_PW.
REQ-028 If REQ-026 and REQ-027 occur in the same cycle, REQ-026 SHALL win.
REQ-029 SEEK: EN=1, DIR=10, ES=0, MC=1, BUSY=1; pulseWidth_max and max_val frozen; SENSOR_VALID ignored.
REQ-030 SEEK SHALL last exactly SETTLE_CYCLES cycles, then return to IDLE with DONE pulsed in the first IDLE cycle.
REQ-031 SENSOR_VALID outside SWEEP SHALL have no effect.
REQ-032 Counters SHALL be 32-bit unsigned, saturation not required within parameter ranges; comparisons unsigned.

Reset
REQ-033 RST SHALL force IDLE from any state on the next edge, including mid-SWEEP or mid-SEEK.
REQ-034 Reset values: EN=0, DIR=00, ES=0, MC=0, BUSY=0, DONE=0, ERR=0, max_val=0, pulseWidth_max=MIN_PW, all counters 0.
REQ-035 RST SHALL take priority over START in the same cycle.

Structure
REQ-036 Shared package sweep_pkg SHALL hold the state encoding, DIR codes (STOP/INC/DEC) and default MIN_PW/MAX_PW constants used by sweep_ctrl and the PWM stage.
REQ-037 Compare-and-hold logic SHALL be a sub-module max_capture (clear, valid, data, position in; max value, max position out).

Verification
REQ-038 RST then START; samples 100@5000, 900@13000, 400@25000 -> SEEK entered, pulseWidth_max=13000, max_val=900, DONE after 200000 SEEK cycles.
REQ-039 Tie: 700@9000 then 700@17000 -> pulseWidth_max=9000.
REQ-040 pulseWidth stuck at 9000 with TIMEOUT_CYCLES=1000 -> ERR pulse at cycle 1000, IDLE, pulseWidth_max=5000.
REQ-041 START asserted during SWEEP and SEEK -> no restart, no max_val clear.
REQ-042 RST mid-SEEK -> next cycle EN=0, DIR=00, MC=0, max_val=0, pulseWidth_max=5000, no DONE.
REQ-043 Largest sample 4095 exactly at pulseWidth=25000 -> captured (pulseWidth_max=25000) and SEEK entered same cycle.
